// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-step sequencer: opcodes, step/state codes,
// instruction classes and the per-step strobe bundle.
package ctrl_pkg;

    localparam int OPC_MAX_W = 16;

    localparam logic [OPC_MAX_W-1:0] OP_LD   = 16'd0;
    localparam logic [OPC_MAX_W-1:0] OP_LDI  = 16'd1;
    localparam logic [OPC_MAX_W-1:0] OP_ST   = 16'd2;
    localparam logic [OPC_MAX_W-1:0] OP_ADD  = 16'd3;
    localparam logic [OPC_MAX_W-1:0] OP_SHL  = 16'd8;
    localparam logic [OPC_MAX_W-1:0] OP_ADDI = 16'd12;
    localparam logic [OPC_MAX_W-1:0] OP_MUL  = 16'd15;
    localparam logic [OPC_MAX_W-1:0] OP_DIV  = 16'd16;
    localparam logic [OPC_MAX_W-1:0] OP_NOP  = 16'd26;
    localparam logic [OPC_MAX_W-1:0] OP_HALT = 16'd27;

    localparam logic [OPC_MAX_W-1:0] ALU_ADD = OP_ADD;

    // IDLE and HALTED both report this step index.
    localparam logic [3:0] STEP_IDLE = 4'd15;

    typedef enum logic [3:0] {
        S_T0     = 4'd0,
        S_T1     = 4'd1,
        S_T2     = 4'd2,
        S_T3     = 4'd3,
        S_T4     = 4'd4,
        S_T5     = 4'd5,
        S_T6     = 4'd6,
        S_T7     = 4'd7,
        S_HALTED = 4'd14,
        S_IDLE   = 4'd15
    } state_t;

    typedef enum logic [3:0] {
        CL_LD, CL_LDI, CL_ST, CL_ALU, CL_ADDI, CL_MULDIV, CL_NOP, CL_HALT, CL_ILLEGAL
    } iclass_t;

    typedef struct packed {
        logic PCout;
        logic Zhighout;
        logic Zlowout;
        logic MDRout;
        logic Cout;
        logic Rout;
        logic BAout;
        logic PCin;
        logic IRin;
        logic MARin;
        logic MDRin;
        logic Yin;
        logic Zin;
        logic HIin;
        logic LOin;
        logic Rin;
        logic Gra;
        logic Grb;
        logic Grc;
        logic IncPC;
        logic Read;
        logic Write;
    } strobes_t;

    function automatic iclass_t decode_class(input logic [OPC_MAX_W-1:0] op);
        if (op == OP_LD)                     return CL_LD;
        if (op == OP_LDI)                    return CL_LDI;
        if (op == OP_ST)                     return CL_ST;
        if (op >= OP_ADD && op <= OP_SHL)    return CL_ALU;
        if (op == OP_ADDI)                   return CL_ADDI;
        if (op == OP_MUL || op == OP_DIV)    return CL_MULDIV;
        if (op == OP_NOP)                    return CL_NOP;
        if (op == OP_HALT)                   return CL_HALT;
        return CL_ILLEGAL;
    endfunction

    // Final T-step of each class; halt and undefined opcodes finish at T3.
    function automatic state_t last_step(input iclass_t c);
        case (c)
            CL_LD, CL_ST:             return S_T7;
            CL_LDI, CL_ALU, CL_ADDI:  return S_T5;
            CL_MULDIV:                return S_T6;
            default:                  return S_T3;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode from (state, instruction class, mem_ready).
// Zero latency; MDRin on memory-read steps is qualified by mem_ready.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 5
) (
    input  state_t                state,
    input  iclass_t               cls,
    input  logic                  mem_ready,
    input  logic [OPCODE_W-1:0]   opcode,
    output strobes_t              strb,
    output logic [OPCODE_W-1:0]   alu_op,
    output logic                  illegal_op
);

    localparam logic [OPCODE_W-1:0] ADD_OP = OPCODE_W'(ALU_ADD);

    always_comb begin
        strb       = '0;
        alu_op     = '0;
        illegal_op = 1'b0;
        case (state)
            S_T0: begin
                strb.PCout = 1'b1; strb.MARin = 1'b1; strb.IncPC = 1'b1; strb.Zin = 1'b1;
                alu_op = ADD_OP;
            end
            S_T1: begin
                strb.Zlowout = 1'b1; strb.PCin = 1'b1; strb.Read = 1'b1;
                strb.MDRin = mem_ready;
            end
            S_T2: begin
                strb.MDRout = 1'b1; strb.IRin = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CL_LD, CL_LDI, CL_ST: begin
                        strb.Grb = 1'b1; strb.BAout = 1'b1; strb.Yin = 1'b1;
                    end
                    CL_ALU, CL_ADDI: begin
                        strb.Grb = 1'b1; strb.Rout = 1'b1; strb.Yin = 1'b1;
                    end
                    CL_MULDIV: begin
                        strb.Gra = 1'b1; strb.Rout = 1'b1; strb.Yin = 1'b1;
                    end
                    CL_ILLEGAL: illegal_op = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    CL_LD, CL_LDI, CL_ST, CL_ADDI: begin
                        strb.Cout = 1'b1; strb.Zin = 1'b1; alu_op = ADD_OP;
                    end
                    CL_ALU: begin
                        strb.Grc = 1'b1; strb.Rout = 1'b1; strb.Zin = 1'b1; alu_op = opcode;
                    end
                    CL_MULDIV: begin
                        strb.Grb = 1'b1; strb.Rout = 1'b1; strb.Zin = 1'b1; alu_op = opcode;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    CL_LD, CL_ST: begin
                        strb.Zlowout = 1'b1; strb.MARin = 1'b1;
                    end
                    CL_LDI, CL_ALU, CL_ADDI: begin
                        strb.Zlowout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1;
                    end
                    CL_MULDIV: begin
                        strb.Zlowout = 1'b1; strb.LOin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    CL_LD: begin
                        strb.Read = 1'b1; strb.MDRin = mem_ready;
                    end
                    CL_ST: begin
                        strb.Gra = 1'b1; strb.Rout = 1'b1; strb.MDRin = 1'b1;
                    end
                    CL_MULDIV: begin
                        strb.Zhighout = 1'b1; strb.HIin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    CL_LD: begin
                        strb.MDRout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1;
                    end
                    CL_ST: strb.Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired T-step sequencer: steps IDLE/T0..T7/HALTED per instruction class.
// Memory steps stall on mem_ready; a wait beyond MEM_WAIT_MAX halts with mem_timeout.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W     = 5,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                clock,
    input  logic                clear_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                Zhighout,
    output logic                Zlowout,
    output logic                MDRout,
    output logic                Cout,
    output logic                Rout,
    output logic                BAout,
    output logic                PCin,
    output logic                IRin,
    output logic                MARin,
    output logic                MDRin,
    output logic                Yin,
    output logic                Zin,
    output logic                HIin,
    output logic                LOin,
    output logic                Rin,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                IncPC,
    output logic                Read,
    output logic                Write,
    output logic [OPCODE_W-1:0] alu_op,
    output logic [3:0]          step,
    output logic                halted,
    output logic                illegal_op,
    output logic                mem_timeout
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

    state_t           state;
    state_t           advance;
    iclass_t          cls;
    logic             mem_step;
    logic [CNT_W-1:0] wait_cnt;
    strobes_t         strb;

    assign cls = decode_class(OPC_MAX_W'(ir_opcode));

    always_comb begin
        mem_step = (state == S_T1) ||
                   (state == S_T6 && cls == CL_LD) ||
                   (state == S_T7 && cls == CL_ST);
        if (state == S_T3 && cls == CL_HALT)
            advance = S_HALTED;
        else if (state == last_step(cls))
            advance = run ? S_T0 : S_IDLE;
        else
            advance = state_t'(state + 4'd1);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE:   if (run) state <= S_T0;
                S_HALTED: ;
                default: begin
                    // Ready in the final wait cycle still completes the access.
                    if (mem_step && !mem_ready) begin
                        if (wait_cnt == CNT_W'(MEM_WAIT_MAX)) begin
                            mem_timeout <= 1'b1;
                            state       <= S_HALTED;
                            wait_cnt    <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                    end else begin
                        wait_cnt <= '0;
                        state    <= advance;
                    end
                end
            endcase
        end
    end

    ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .state      (state),
        .cls        (cls),
        .mem_ready  (mem_ready),
        .opcode     (ir_opcode),
        .strb       (strb),
        .alu_op     (alu_op),
        .illegal_op (illegal_op)
    );

    assign step   = (state == S_IDLE || state == S_HALTED) ? STEP_IDLE : 4'(state);
    assign halted = (state == S_HALTED);

    assign PCout    = strb.PCout;
    assign Zhighout = strb.Zhighout;
    assign Zlowout  = strb.Zlowout;
    assign MDRout   = strb.MDRout;
    assign Cout     = strb.Cout;
    assign Rout     = strb.Rout;
    assign BAout    = strb.BAout;
    assign PCin     = strb.PCin;
    assign IRin     = strb.IRin;
    assign MARin    = strb.MARin;
    assign MDRin    = strb.MDRin;
    assign Yin      = strb.Yin;
    assign Zin      = strb.Zin;
    assign HIin     = strb.HIin;
    assign LOin     = strb.LOin;
    assign Rin      = strb.Rin;
    assign Gra      = strb.Gra;
    assign Grb      = strb.Grb;
    assign Grc      = strb.Grc;
    assign IncPC    = strb.IncPC;
    assign Read     = strb.Read;
    assign Write    = strb.Write;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: per-step strobe tables, memory waits,
// timeout, illegal/halt opcodes and asynchronous clear.
module tb_ctrl_sequencer;

    logic       clock = 1'b0;
    logic       clear_n = 1'b1;
    logic       run = 1'b0;
    logic [4:0] ir_opcode = '0;
    logic       mem_ready = 1'b0;
    logic PCout, Zhighout, Zlowout, MDRout, Cout, Rout, BAout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, Gra, Grb, Grc;
    logic IncPC, Read, Write;
    logic [4:0] alu_op;
    logic [3:0] step;
    logic halted, illegal_op, mem_timeout;

    logic [21:0] strb;
    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [21:0] M_PCOUT    = 22'(1) << 21;
    localparam logic [21:0] M_ZHIGHOUT = 22'(1) << 20;
    localparam logic [21:0] M_ZLOWOUT  = 22'(1) << 19;
    localparam logic [21:0] M_MDROUT   = 22'(1) << 18;
    localparam logic [21:0] M_COUT     = 22'(1) << 17;
    localparam logic [21:0] M_ROUT     = 22'(1) << 16;
    localparam logic [21:0] M_BAOUT    = 22'(1) << 15;
    localparam logic [21:0] M_PCIN     = 22'(1) << 14;
    localparam logic [21:0] M_IRIN     = 22'(1) << 13;
    localparam logic [21:0] M_MARIN    = 22'(1) << 12;
    localparam logic [21:0] M_MDRIN    = 22'(1) << 11;
    localparam logic [21:0] M_YIN      = 22'(1) << 10;
    localparam logic [21:0] M_ZIN      = 22'(1) << 9;
    localparam logic [21:0] M_HIIN     = 22'(1) << 8;
    localparam logic [21:0] M_LOIN     = 22'(1) << 7;
    localparam logic [21:0] M_RIN      = 22'(1) << 6;
    localparam logic [21:0] M_GRA      = 22'(1) << 5;
    localparam logic [21:0] M_GRB      = 22'(1) << 4;
    localparam logic [21:0] M_GRC      = 22'(1) << 3;
    localparam logic [21:0] M_INCPC    = 22'(1) << 2;
    localparam logic [21:0] M_READ     = 22'(1) << 1;
    localparam logic [21:0] M_WRITE    = 22'(1);

    localparam logic [21:0] F_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [21:0] F_T1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
    localparam logic [21:0] F_T2 = M_MDROUT | M_IRIN;

    assign strb = {PCout, Zhighout, Zlowout, MDRout, Cout, Rout, BAout, PCin, IRin,
                   MARin, MDRin, Yin, Zin, HIin, LOin, Rin, Gra, Grb, Grc, IncPC, Read, Write};

    always #5 clock = ~clock;

    ctrl_sequencer #(.OPCODE_W(5), .MEM_WAIT_MAX(15)) dut (
        .clock(clock), .clear_n(clear_n), .run(run), .ir_opcode(ir_opcode), .mem_ready(mem_ready),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
        .Rout(Rout), .BAout(BAout), .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .Rin(Rin), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write), .alu_op(alu_op), .step(step),
        .halted(halted), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        run = 1'b0; mem_ready = 1'b0; ir_opcode = '0;
        clear_n = 1'b1;
        #1;
        clear_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        clear_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if (step !== 4'd15) $display("FAIL reset_step got %0d want 15", step); else n_pass++;
        n_checks++;
        if (strb !== 22'd0) $display("FAIL reset_strobes got %h want 0", strb); else n_pass++;
        n_checks++;
        if ({alu_op, halted, illegal_op, mem_timeout} !== 8'd0)
            $display("FAIL reset_flags got alu=%h h=%b i=%b t=%b want all 0",
                     alu_op, halted, illegal_op, mem_timeout);
        else n_pass++;
    endtask

    task automatic test_ld;
        logic [21:0] es[8];
        logic [4:0]  ea[8];
        es = '{F_T0, F_T1, F_T2, M_GRB | M_BAOUT | M_YIN, M_COUT | M_ZIN,
               M_ZLOWOUT | M_MARIN, M_READ | M_MDRIN, M_MDROUT | M_GRA | M_RIN};
        ea = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0};
        ir_opcode = 5'b00000; mem_ready = 1'b1; run = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (step !== 4'(i) || strb !== es[i] || alu_op !== ea[i])
                $display("FAIL ld_T%0d got step=%0d strb=%h alu=%h want step=%0d strb=%h alu=%h",
                         i, step, strb, alu_op, i, es[i], ea[i]);
            else n_pass++;
            if (i == 0) run = 1'b0;
            tick();
        end
        n_checks++;
        if (step !== 4'd15 || strb !== 22'd0)
            $display("FAIL ld_idle got step=%0d strb=%h want step=15 strb=0", step, strb);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [21:0] es[6];
        logic [4:0]  ea[6];
        es = '{F_T0, F_T1, F_T2, M_GRB | M_ROUT | M_YIN, M_GRC | M_ROUT | M_ZIN,
               M_ZLOWOUT | M_GRA | M_RIN};
        ea = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0};
        ir_opcode = 5'b00011; mem_ready = 1'b1; run = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (step !== 4'(i) || strb !== es[i] || alu_op !== ea[i])
                $display("FAIL add_T%0d got step=%0d strb=%h alu=%h want step=%0d strb=%h alu=%h",
                         i, step, strb, alu_op, i, es[i], ea[i]);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (step !== 4'd0 || strb !== F_T0)
            $display("FAIL b2b_restart got step=%0d strb=%h want step=0 strb=%h", step, strb, F_T0);
        else n_pass++;
        ir_opcode = 5'b00100; run = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (step !== 4'd4 || alu_op !== 5'b00100 || strb !== (M_GRC | M_ROUT | M_ZIN))
            $display("FAIL sub_T4 got step=%0d alu=%h strb=%h want step=4 alu=04 strb=%h",
                     step, alu_op, strb, M_GRC | M_ROUT | M_ZIN);
        else n_pass++;
        repeat (2) tick();
        n_checks++;
        if (step !== 4'd15) $display("FAIL sub_idle got step=%0d want 15", step); else n_pass++;
    endtask

    task automatic test_mul;
        ir_opcode = 5'b01111; mem_ready = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) begin
                n_checks++;
                if (strb !== (M_ZLOWOUT | M_LOIN))
                    $display("FAIL mul_T5 got strb=%h want %h", strb, M_ZLOWOUT | M_LOIN);
                else n_pass++;
            end
            if (i == 6) begin
                n_checks++;
                if (strb !== (M_ZHIGHOUT | M_HIIN))
                    $display("FAIL mul_T6 got strb=%h want %h", strb, M_ZHIGHOUT | M_HIIN);
                else n_pass++;
            end
            tick();
        end
        n_checks++;
        if (step !== 4'd15) $display("FAIL mul_latency got step=%0d want 15 after 7 cycles", step);
        else n_pass++;
    endtask

    task automatic test_ld_wait;
        int cycles = 0, t6 = 0, reads = 0, mdr = 0;
        ir_opcode = 5'b00000; mem_ready = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        while (step !== 4'd15 && cycles < 40) begin
            cycles++;
            if (step == 4'd6) begin
                mem_ready = (t6 >= 3);
                #1;
                if (Read) reads++;
                if (MDRin) mdr++;
                t6++;
            end else begin
                mem_ready = 1'b1;
            end
            tick();
        end
        mem_ready = 1'b1;
        n_checks++;
        if (cycles != 11) $display("FAIL ldwait_cycles got %0d want 11", cycles); else n_pass++;
        n_checks++;
        if (reads != 4) $display("FAIL ldwait_read got %0d cycles want 4", reads); else n_pass++;
        n_checks++;
        if (mdr != 1) $display("FAIL ldwait_mdrin got %0d cycles want 1", mdr); else n_pass++;
    endtask

    task automatic test_st_timeout;
        int cycles = 0, wr = 0, early = 0;
        ir_opcode = 5'b00010; mem_ready = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        while (step !== 4'd15 && cycles < 60) begin
            cycles++;
            if (step == 4'd7) begin
                mem_ready = 1'b0;
                if (Write) wr++;
                if (mem_timeout) early++;
            end else begin
                mem_ready = 1'b1;
            end
            tick();
        end
        n_checks++;
        if (wr != 16) $display("FAIL st_write_hold got %0d cycles want 16", wr); else n_pass++;
        n_checks++;
        if (early != 0) $display("FAIL st_early_timeout got %0d want 0", early); else n_pass++;
        n_checks++;
        if ({halted, mem_timeout} !== 2'b11)
            $display("FAIL st_timeout got halted=%b mem_timeout=%b want 1 1", halted, mem_timeout);
        else n_pass++;
        n_checks++;
        if (strb !== 22'd0 || step !== 4'd15)
            $display("FAIL st_halt_outputs got strb=%h step=%0d want 0 15", strb, step);
        else n_pass++;
        run = 1'b1; mem_ready = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (halted !== 1'b1 || mem_timeout !== 1'b1 || step !== 4'd15)
            $display("FAIL st_sticky got halted=%b timeout=%b step=%0d want 1 1 15",
                     halted, mem_timeout, step);
        else n_pass++;
        run = 1'b0;
    endtask

    task automatic test_illegal_halt;
        int pulses = 0;
        do_reset();
        ir_opcode = 5'b11111; mem_ready = 1'b1; run = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (illegal_op) pulses++;
            if (i == 3) begin
                n_checks++;
                if (step !== 4'd3 || illegal_op !== 1'b1 || strb !== 22'd0)
                    $display("FAIL illegal_T3 got step=%0d ill=%b strb=%h want 3 1 0",
                             step, illegal_op, strb);
                else n_pass++;
            end
            tick();
        end
        n_checks++;
        if (step !== 4'd0 || illegal_op !== 1'b0)
            $display("FAIL illegal_restart got step=%0d ill=%b want 0 0", step, illegal_op);
        else n_pass++;
        n_checks++;
        if (pulses != 1) $display("FAIL illegal_pulses got %0d want 1", pulses); else n_pass++;
        ir_opcode = 5'b11011;
        repeat (4) tick();
        n_checks++;
        if (halted !== 1'b1 || step !== 4'd15 || strb !== 22'd0 || mem_timeout !== 1'b0)
            $display("FAIL halt_state got halted=%b step=%0d strb=%h to=%b want 1 15 0 0",
                     halted, step, strb, mem_timeout);
        else n_pass++;
        run = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (halted !== 1'b1) $display("FAIL halt_hold got halted=%b want 1", halted); else n_pass++;
        clear_n = 1'b0;
        #1;
        n_checks++;
        if (halted !== 1'b0 || step !== 4'd15)
            $display("FAIL halt_clear got halted=%b step=%0d want 0 15", halted, step);
        else n_pass++;
        clear_n = 1'b1;
    endtask

    task automatic test_reset_mid;
        do_reset();
        ir_opcode = 5'b00000; mem_ready = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (step !== 4'd5 || strb !== (M_ZLOWOUT | M_MARIN))
            $display("FAIL mid_T5 got step=%0d strb=%h want 5 %h", step, strb, M_ZLOWOUT | M_MARIN);
        else n_pass++;
        clear_n = 1'b0;
        #1;
        n_checks++;
        if (step !== 4'd15 || strb !== 22'd0 || alu_op !== 5'd0)
            $display("FAIL mid_async got step=%0d strb=%h alu=%h want 15 0 0", step, strb, alu_op);
        else n_pass++;
        repeat (2) @(posedge clock);
        #1;
        clear_n = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (step !== 4'd15) $display("FAIL mid_stay_idle got step=%0d want 15", step); else n_pass++;
        run = 1'b1;
        tick();
        n_checks++;
        if (step !== 4'd0 || strb !== F_T0)
            $display("FAIL mid_restart got step=%0d strb=%h want 0 %h", step, strb, F_T0);
        else n_pass++;
        run = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ld();
        test_back_to_back();
        test_mul();
        test_ld_wait();
        test_st_timeout();
        test_illegal_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Hardwired control-step sequencer that replaces hand-driven T0..Tn strobe sequences with an FSM generating every datapath control signal for each instruction class. It sits beside `datapath`, reads the IR opcode field, and drives bus-out, register-in, ALU-op and memory strobes. Generalisations: parametrised opcode width, a variable step count per instruction class, and a memory-ready handshake with timeout in place of fixed-delay reads.

## Interface
- OPCODE_W, 5, opcode field width (IR[31:27])
- MEM_WAIT_MAX, 15, cycles a memory step may wait for `mem_ready` before timeout
- Clock  in  1  system clock, rising edge
- clear_n  in  1  asynchronous, active-low reset
- run  in  1  level: start/continue fetching instructions
- ir_opcode  in  OPCODE_W  opcode from IR, valid from the cycle after IRin
- mem_ready  in  1  memory completes the current Read/Write this cycle
- PCout, Zhighout, Zlowout, MDRout, Cout, Rout, BAout  out  1 each  bus drivers
- PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, Gra, Grb, Grc  out  1 each  load/select strobes
- IncPC, Read, Write  out  1 each  PC increment and memory strobes
- alu_op  out  OPCODE_W  ALU operation, valid whenever Zin=1, else 0
- step  out  4  current T-step index (0..7), 15 in IDLE/HALTED
- halted  out  1  high in HALTED
- illegal_op  out  1  one-cycle pulse on undefined opcode
- mem_timeout  out  1  sticky until reset

## Operation
- States: IDLE, T0..T7, HALTED. Moore outputs decoded from state (plus `mem_ready` for MDRin qualification).
- IDLE: all strobes 0; `run`=1 -> T0. `run` is sampled only in IDLE and at the last step of an instruction.
- Fetch: T0 PCout,MARin,IncPC,Zin (alu_op=ADD); T1 Zlowout,PCin,Read, MDRin only when mem_ready; T2 MDRout,IRin.
- T3 onward, by class of `ir_opcode`:
  - ld (00000)/ldi (00001): T3 Grb,BAout,Yin; T4 Cout,Zin,alu_op=ADD; T5 Zlowout, then MARin (ld) or Gra,Rin (ldi, ends); ld continues T6 Read, MDRin on ready; T7 MDRout,Gra,Rin.
  - st (00010): T3-T5 as ld; T6 Gra,Rout,MDRin; T7 Write held until ready.
  - reg ALU add/sub/and/or/shr/shl (00011..01000): T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,alu_op=opcode; T5 Zlowout,Gra,Rin.
  - addi (01100): T3 Grb,Rout,Yin; T4 Cout,Zin,alu_op=ADD; T5 Zlowout,Gra,Rin.
  - mul (01111)/div (10000): T3 Gra,Rout,Yin; T4 Grb,Rout,Zin; T5 Zlowout,LOin; T6 Zhighout,HIin.
  - nop (11010): ends at T3. halt (11011): T3 -> HALTED.
  - other: illegal_op pulse in T3, return to T0/IDLE.
- After the last step: `run`=1 -> T0, else IDLE.
- Memory wait (T1, ld T6, st T7): state holds, Read/Write held high; counter increments; reaching MEM_WAIT_MAX without ready -> set mem_timeout, deassert all strobes, go to HALTED.
- HALTED exits only via clear_n.

## Timing
- Reset: state IDLE, every output 0 except step=15; asynchronous and immediate, including mid-instruction.
- Zero-wait latency (T0 entry to last step): ld 8, st 8, ldi 6, ALU/addi 6, mul/div 7, nop 4 cycles.
- Each memory wait cycle adds 1; wait counter clears on step exit.
- `mem_ready` during a non-memory step is ignored.
- Simultaneous ready and counter==MEM_WAIT_MAX: ready wins.

## Structure
- Package `ctrl_pkg`: opcode constants, ALU_ADD, step encoding, IDLE/HALTED codes, instruction-class enum, and a `decode_class` function.
- One sub-module `ctrl_decode`: combinational mapping from (state, class, mem_ready) to the strobe vector. Sequencing and wait counting stay in the top.

## Test plan
- Reset then run=1, ir_opcode=00000, mem_ready always 1 -> T0..T7 in 8 cycles; T7 has MDRout,Gra,Rin; run low -> IDLE, step=15.
- add (00011), zero wait -> T4 shows alu_op=00011 with Zin; T5 Zlowout,Gra,Rin; next instruction starts at T0.
- ld with mem_ready delayed 3 cycles in T6 -> Read high for 4 cycles, MDRin only in the ready cycle, total 11 cycles.
- st with mem_ready never asserted -> after 15 wait cycles mem_timeout=1, halted=1, all strobes 0.
- opcode 11111 -> illegal_op single pulse in T3, fetch restarts; halt (11011) -> halted=1 until clear_n.
- clear_n low during ld T5 -> all strobes 0 immediately, step=15; on release sequencer stays IDLE until run.
